// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction-fetch queue: default sizing,
// sequential PC step, the NOP encoding and the word-alignment mask.
package ifetch_queue_pkg;

    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned MAX_OUT_DEF   = 2;
    localparam logic [31:0] FETCH_PC_STEP = 32'd4;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_queue_slot_ram.sv
// fetch_slot_ram: DEPTH entries of {pc, instr}. The pc field is written at
// grant time (tail) and the instr field at response time (fill), so the two
// halves have independent write ports. Read is asynchronous at head.
module fetch_slot_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          pc_we,
    input  logic [AW-1:0] pc_waddr,
    input  logic [31:0]   pc_wdata,
    input  logic          instr_we,
    input  logic [AW-1:0] instr_waddr,
    input  logic [31:0]   instr_wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_instr
);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    // Capture the request address when the slot is allocated.
    always_ff @(posedge clk) begin
        if (pc_we) pc_mem[pc_waddr] <= pc_wdata;
    end

    // Capture the instruction word when its response returns.
    always_ff @(posedge clk) begin
        if (instr_we) instr_mem[instr_waddr] <= instr_wdata;
    end

    assign rd_pc    = pc_mem[raddr];
    assign rd_instr = instr_mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage behind the PC register. Issues in-order imem
// reads, buffers {pc, instr} in a slot queue and hands them to decode.
// A redirect empties the queue and arranges for every in-flight response to
// be discarded via drop_cnt.
//
// Handshake: a transfer to decode happens in any cycle where if_valid and
// id_ready are both high; if_valid never depends on id_ready, and if_pc /
// if_instr are stable while if_valid is held. imem_req is a pure function of
// the current state, redirect and clrn; a request is accepted when imem_req
// and imem_gnt are both high.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF,
    parameter logic [31:0] PC_STEP = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   PW        = AW + 1;
    localparam int unsigned   CW        = $clog2(MAX_OUT + 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PW-1:0] head, fill, tail, occ;
    logic [CW-1:0] out_cnt, drop_cnt;
    logic          grant, resp, keep, pop;
    logic [31:0]   ram_pc, ram_instr, hold_pc, hold_instr;

    assign occ       = tail - head;
    assign imem_req  = clrn & ~redirect & (occ < DEPTH_P) & (out_cnt < MAX_OUT_C);
    assign imem_addr = pc;
    assign grant     = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = imem_rvalid & (out_cnt != '0);
    assign keep      = resp & ~redirect & (drop_cnt == '0);
    assign if_valid  = (fill != head);
    assign pop       = if_valid & id_ready & ~redirect;

    assign pc_next = redirect ? (redirect_pc & PC_ALIGN_MASK)
                   : grant    ? (pc + PC_STEP)
                   : pc;

    fetch_slot_ram #(.DEPTH(DEPTH), .AW(AW)) u_slots (
        .clk         (clk),
        .pc_we       (grant),
        .pc_waddr    (tail[AW-1:0]),
        .pc_wdata    (pc),
        .instr_we    (keep),
        .instr_waddr (fill[AW-1:0]),
        .instr_wdata (imem_rdata),
        .raddr       (head[AW-1:0]),
        .rd_pc       (ram_pc),
        .rd_instr    (ram_instr)
    );

    // Pointer and outstanding/drop bookkeeping; redirect overrides everything.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            head     <= tail;
            fill     <= tail;
            out_cnt  <= out_cnt - CW'(resp);
            drop_cnt <= out_cnt - CW'(resp);
        end else begin
            if (grant) tail <= tail + PW'(1);
            if (keep)  fill <= fill + PW'(1);
            if (pop)   head <= head + PW'(1);
            out_cnt <= out_cnt + CW'(grant) - CW'(resp);
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Remember the last presented instruction so outputs hold while empty.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hold_pc    <= '0;
            hold_instr <= NOP_WORD;
        end else if (if_valid) begin
            hold_pc    <= ram_pc;
            hold_instr <= ram_instr;
        end
    end

    assign if_pc    = if_valid ? ram_pc    : hold_pc;
    assign if_instr = if_valid ? ram_instr : hold_instr;

    // Memory must never return data that was not requested.
    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (!clrn) imem_rvalid |-> (out_cnt != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: an in-order memory model with per-request
// latency and epoch tags, a granted-address scoreboard, directed scenarios
// and a randomized phase.
`timescale 1ns/1ps
module tb_ifetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk, clrn;
    logic [31:0] pc, pc_next, redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;
    logic        redirect, imem_req, imem_gnt, imem_rvalid, if_valid, id_ready;

    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .PC_STEP(32'd4)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .pc          (pc),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .id_ready    (id_ready)
    );

    // ---------------- clock / reset / PC register ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) pc <= 32'h0;
        else       pc <= pc_next;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       pend_q[$];   // memory: every granted request not yet answered
    logic [31:0] exp_q[$];    // granted addresses of the live epoch, not yet popped
    int          arrived_n;   // leading entries of exp_q whose data has returned
    int          epoch;
    logic [31:0] last_pc, last_instr;

    int  cyc, n_tests, n_fail;
    int  lat_min, lat_max, gnt_pct, rdy_pct, redir_pm;
    bit  redir_now, redir_on_collision, collision_hit, release_pending;
    logic [31:0] redir_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int g, input int r, input int rpm);
        lat_min = lmin; lat_max = lmax; gnt_pct = g; rdy_pct = r; redir_pm = rpm;
    endtask

    // ---------------- driver + compare: one clock cycle ----------------
    task automatic step();
        bit          rv, exp_valid, exp_req, grant, pop;
        logic [31:0] exp_next;
        mreq_t       m;
        @(posedge clk);
        #1;
        cyc++;
        if (release_pending) begin
            clrn = 1'b1;
            release_pending = 1'b0;
        end
        id_ready    = (int'($urandom_range(99)) < rdy_pct);
        imem_gnt    = (int'($urandom_range(99)) < gnt_pct);
        rv          = clrn && (pend_q.size() > 0) && (pend_q[0].ready <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend_q[0].addr) : $urandom();
        exp_valid   = (arrived_n > 0);
        redirect    = 1'b0;
        redirect_pc = $urandom();
        if (clrn) begin
            if (redir_now) begin
                redirect = 1'b1; redirect_pc = redir_target; redir_now = 1'b0;
            end else if (redir_on_collision && rv && exp_valid && id_ready) begin
                redirect = 1'b1; redir_on_collision = 1'b0; collision_hit = 1'b1;
            end else if (int'($urandom_range(999)) < redir_pm) begin
                redirect = 1'b1;
            end
        end
        @(negedge clk);
        if (!clrn) begin
            chk("reset_if_valid", if_valid, 0);
            chk("reset_imem_req", imem_req, 0);
            return;
        end
        exp_req  = !redirect && (exp_q.size() < DEPTH) && (pend_q.size() < MAX_OUT);
        grant    = exp_req && imem_gnt;
        exp_next = redirect ? {redirect_pc[31:2], 2'b00} : grant ? pc + 32'd4 : pc;
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, pc);
        chk("pc_next", pc_next, exp_next);
        chk("if_valid", if_valid, exp_valid);
        if (exp_valid) begin
            chk("if_pc", if_pc, exp_q[0]);
            chk("if_instr", if_instr, mem_word(exp_q[0]));
            last_pc    = exp_q[0];
            last_instr = mem_word(exp_q[0]);
        end else begin
            chk("if_pc_hold", if_pc, last_pc);
            chk("if_instr_hold", if_instr, last_instr);
        end
        // advance the model by this cycle's events
        pop = exp_valid && id_ready && !redirect;
        if (rv) begin
            m = pend_q.pop_front();
            if (!redirect && (m.epoch == epoch)) arrived_n++;
        end
        if (redirect) begin
            exp_q.delete();
            arrived_n = 0;
            epoch++;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                arrived_n--;
            end
            if (grant) exp_q.push_back(pc);
        end
        if (grant) begin
            m.addr  = pc;
            m.epoch = epoch;
            m.ready = cyc + int'($urandom_range(lat_max, lat_min));
            pend_q.push_back(m);
        end
    endtask

    // Drop clrn between edges, check the immediate effect, release later.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        cyc++;
        clrn = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("rst_now_if_valid", if_valid, 0);
        chk("rst_now_imem_req", imem_req, 0);
        chk("rst_now_if_pc", if_pc, 0);
        chk("rst_now_if_instr", if_instr, 0);
        chk("rst_now_pc", pc, 0);
        pend_q.delete();
        exp_q.delete();
        arrived_n = 0; epoch++;
        last_pc = 32'h0; last_instr = 32'h0;
        repeat (hold) step();
        release_pending = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; arrived_n = 0;
        last_pc = 32'h0; last_instr = 32'h0;
        redir_now = 0; redir_on_collision = 0; collision_hit = 0; release_pending = 0;
        redir_target = 32'h0;
        clrn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        set_knobs(1, 1, 100, 100, 0);

        // T1: 1-cycle memory, streaming; first valid two cycles after release
        do_reset(2);
        for (int k = 0; k < 7; k++) begin
            step();
            if (k < 2) chk("t1_not_yet_valid", if_valid, 0);
            else begin
                chk("t1_valid", if_valid, 1);
                chk("t1_if_pc", if_pc, 32'(4 * (k - 2)));
            end
        end

        // T2: decode stalled, queue fills at 4 entries, pc parks at 0x10
        set_knobs(1, 1, 100, 0, 0);
        do_reset(2);
        repeat (8) step();
        chk("t2_req_full", imem_req, 0);
        chk("t2_pc_hold", pc, 32'h10);
        chk("t2_if_pc_head", if_pc, 32'h0);
        rdy_pct = 100;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_pop_order", if_pc, 32'(4 * k));
            if (k == 1) begin
                chk("t2_req_resume", imem_req, 1);
                chk("t2_addr_resume", imem_addr, 32'h10);
            end
        end

        // T3: 3-cycle memory, redirect with two in flight
        set_knobs(3, 3, 100, 100, 0);
        do_reset(2);
        step(); step();
        redir_now = 1; redir_target = 32'h0000_1003;
        step();
        chk("t3_pc_next_aligned", pc_next, 32'h1000);
        step();
        chk("t3_addr", imem_addr, 32'h1000);
        chk("t3_no_req_out_full", imem_req, 0);
        chk("t3_dropped_a", if_valid, 0);
        step();
        chk("t3_dropped_b", if_valid, 0);
        chk("t3_req_at_target", imem_req, 1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (if_valid) found = 1;
        end
        chk("t3_first_valid_seen", found, 1);
        chk("t3_first_if_pc", if_pc, 32'h1000);

        // T4: redirect coinciding with a pop and a response
        set_knobs(2, 2, 100, 100, 0);
        redir_on_collision = 1; collision_hit = 0;
        for (int k = 0; k < 50 && !collision_hit; k++) step();
        chk("t4_collision_seen", collision_hit, 1);
        redir_on_collision = 0;
        step();
        chk("t4_empty_after", if_valid, 0);
        repeat (10) step();

        // T5: address wrap at the top of the 32-bit space
        set_knobs(1, 1, 100, 100, 0);
        redir_now = 1; redir_target = 32'hFFFF_FFFC;
        step(); step();
        chk("t5_pc", pc, 32'hFFFF_FFFC);
        chk("t5_pc_next_wrap", pc_next, 32'h0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (if_valid) found = 1;
        end
        chk("t5_valid_seen", found, 1);
        chk("t5_if_pc_top", if_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_if_pc_wrapped", if_pc, 32'h0);

        // T6: reset while full with two requests outstanding
        set_knobs(4, 4, 100, 0, 0);
        do_reset(1);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (exp_q.size() == DEPTH && pend_q.size() == 2) found = 1;
        end
        chk("t6_full_inflight", found, 1);
        set_knobs(1, 1, 100, 100, 0);
        do_reset(2);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (if_valid) found = 1;
        end
        chk("t6_restart_seen", found, 1);
        chk("t6_restart_pc", if_pc, 32'h0);

        // Randomized phase
        for (int blk = 0; blk < 30; blk++) begin
            lat_min  = int'($urandom_range(3, 1));
            lat_max  = lat_min + int'($urandom_range(3));
            gnt_pct  = int'($urandom_range(100, 30));
            rdy_pct  = int'($urandom_range(100, 20));
            redir_pm = int'($urandom_range(60));
            if ($urandom_range(7) == 0) do_reset(2);
            repeat (100) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
